// File: rtl/fetch_pkg.sv
// Shared types for the fetch front-end: queue entry layout, FSM states and the canonical NOP.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FLUSH
  } fq_state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fq_fifo.sv
// Synchronous FIFO with flush; used for the decode queue and the in-flight PC list.
module fq_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_b,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DepthCnt);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; reads are qualified by empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  overflow_a: assert property (@(posedge clk) disable iff (reset_b)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front-end: owns fetch PC, issues imem requests, buffers responses for decode.
// Optional FETCH_BYPASS_EN presents a response combinationally when the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned IMEM_ADDR_WIDTH = 10,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic                       clk,
  input  logic                       reset_b,
  output logic                       imem_req,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_inst,
  input  logic                       out_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DepthSum = (CW+1)'(DEPTH);

  fq_state_t    state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] q_count, infl_count;
  logic         q_full, q_empty, infl_full, infl_empty;
  logic [31:0]  infl_head;
  fetch_entry_t q_head, q_wdata;
  logic         issue, rsp_take, rsp_any, q_push, q_pop;

  // Queue plus in-flight never exceeds DEPTH, so a response always has a slot.
  assign imem_req = (state_q == FETCH) && !redirect_valid && !infl_full && !q_full &&
                    (({1'b0, q_count} + {1'b0, infl_count}) < DepthSum);
  assign imem_addr = fetch_pc_q[IMEM_ADDR_WIDTH+1:2];
  assign issue     = imem_req && imem_gnt;

  assign rsp_take = imem_rvalid && !redirect_valid && (drop_q == '0) && !infl_empty;
  assign rsp_any  = imem_rvalid && ((drop_q != '0) || !infl_empty);
  assign q_wdata  = '{pc: infl_head, inst: imem_rdata};
  assign q_pop    = !q_empty && out_ready && !redirect_valid;

  always_comb begin
    drop_d = drop_q;
    if (redirect_valid) begin
      // Everything still outstanding becomes stale, minus a response landing this cycle.
      drop_d = drop_q + infl_count - {{(CW-1){1'b0}}, rsp_any};
    end else if (imem_rvalid && (drop_q != '0)) begin
      drop_d = drop_q - 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (issue)          fetch_pc_d = fetch_pc_q + 32'd4;
    if (redirect_valid) fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (redirect_valid && (drop_d != '0)) state_d = FLUSH;
      FLUSH:   if (drop_d == '0) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass    = rsp_take && q_empty;
  assign q_push    = rsp_take && !(bypass && out_ready);
  assign out_valid = !q_empty || bypass;
  always_comb begin
    out_pc   = '0;
    out_inst = '0;
    if (!q_empty) begin
      out_pc   = q_head.pc;
      out_inst = q_head.inst;
    end else if (bypass) begin
      out_pc   = infl_head;
      out_inst = imem_rdata;
    end
  end
`else
  assign q_push    = rsp_take;
  assign out_valid = !q_empty;
  assign out_pc    = q_empty ? '0 : q_head.pc;
  assign out_inst  = q_empty ? '0 : q_head.inst;
`endif

  fq_fifo #(
    .WIDTH(32),
    .DEPTH(DEPTH)
  ) u_infl_fifo (
    .clk    (clk),
    .reset_b(reset_b),
    .push   (issue),
    .wdata  (fetch_pc_q),
    .pop    (rsp_take),
    .flush  (redirect_valid),
    .rdata  (infl_head),
    .full   (infl_full),
    .empty  (infl_empty),
    .count  (infl_count)
  );

  fq_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(DEPTH)
  ) u_dec_queue (
    .clk    (clk),
    .reset_b(reset_b),
    .push   (q_push),
    .wdata  (q_wdata),
    .pop    (q_pop),
    .flush  (redirect_valid),
    .rdata  (q_head),
    .full   (q_full),
    .empty  (q_empty),
    .count  (q_count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: variable-latency imem model, sequential-stream reference, scoreboard monitor.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 10;

  logic          clk = 1'b0;
  logic          reset_b = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt = 1'b0;
  logic          imem_rvalid = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          out_valid;
  logic [31:0]   out_pc, out_inst;
  logic          out_ready = 1'b0;

  int checks = 0, errors = 0;
  int acc_cnt = 0, issue_cnt = 0, cyc = 0;
  int mem_lat = 1, gnt_mode = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } pend_t;
  pend_t pend[$];

  fetch_queue #(
    .DEPTH          (DEPTH),
    .IMEM_ADDR_WIDTH(AW),
    .RESET_PC       (32'h0)
  ) dut (
    .clk           (clk),
    .reset_b       (reset_b),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_pc        (out_pc),
    .out_inst      (out_inst),
    .out_ready     (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [AW-1:0] waddr);
    return NOP_INST ^ ({22'd0, waddr} * 32'h9E37_79B1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Redirect for one cycle; the reference stream restarts at the aligned target.
  task automatic redirect(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    exp_q.delete();
    exp_q.push_back(t & 32'hFFFF_FFFC);
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_out(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Instruction memory: in-order responses mem_lat cycles after issue.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_b && imem_req && imem_gnt) begin
        pend.push_back('{addr: imem_addr, due: cyc + mem_lat});
        issue_cnt++;
      end
      @(posedge clk);
      cyc++;
      #1;
      case (gnt_mode)
        0:       imem_gnt = 1'b1;
        1:       imem_gnt = ~imem_gnt;
        default: imem_gnt = 1'($urandom_range(0, 1));
      endcase
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = inst_of(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
      end
    end
  end

  // Monitor: every accepted entry must be the next PC of the reference stream.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!reset_b && !redirect_valid && out_valid && out_ready) begin
        e = exp_q.pop_front();
        chk("out_pc", out_pc, e);
        chk("out_inst", out_inst, inst_of(e[AW+1:2]));
        exp_q.push_back(e + 32'd4);
        acc_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    bit ok;
    int start;
    out_ready = 1'b1;
    exp_q.push_back(32'h0);
    repeat (3) tick();
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_inst", out_inst, 0);

    // 1: first output three cycles after reset release
    tick();
    reset_b = 1'b0;
    @(negedge clk); chk("idle_req", imem_req, 0); chk("lat0_valid", out_valid, 0); tick();
    @(negedge clk); chk("fetch_req", imem_req, 1); chk("lat1_valid", out_valid, 0); tick();
    @(negedge clk); chk("lat2_valid", out_valid, 0); tick();
    @(negedge clk); chk("lat3_valid", out_valid, 1); chk("lat3_pc", out_pc, 0); tick();
    repeat (10) tick();

    // 2: decode stall fills queue, then drains without gaps
    out_ready = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    chk("stall_req", imem_req, 0);
    chk("stall_valid", out_valid, 1);
    chk("stall_occupancy", issue_cnt - acc_cnt, DEPTH);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("drain_nogap", out_valid, 1);
      tick();
    end

    // 3: redirect with requests in flight
    mem_lat = 3;
    repeat (20) tick();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      if (pend.size() >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    chk("t3_inflight_wait", ok, 1);
    redirect(32'h104);
    @(negedge clk);
    chk("t3_cleared", out_valid, 0);
    chk("t3_flush_req", imem_req, 0);
    wait_out(60, ok);
    chk("t3_wait", ok, 1);
    chk("t3_pc", out_pc, 32'h104);
    tick();

    // back-to-back redirects, second one lands during FLUSH
    repeat (15) tick();
    redirect(32'h700);
    redirect(32'h1000);
    wait_out(60, ok);
    chk("t3b_wait", ok, 1);
    chk("t3b_pc", out_pc, 32'h1000);
    tick();

    // 4: redirect, rvalid and out_ready in the same cycle
    mem_lat = 1;
    repeat (12) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3F0;
    exp_q.delete();
    exp_q.push_back(32'h3F0);
    @(negedge clk);
    chk("t4_valid_before", out_valid, 1);
    chk("t4_req_blocked", imem_req, 0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t4_cleared", out_valid, 0);
    wait_out(20, ok);
    chk("t4_wait", ok, 1);
    chk("t4_pc", out_pc, 32'h3F0);
    tick();

    // 5: unaligned redirect target
    repeat (5) tick();
    redirect(32'h203);
    @(negedge clk);
    chk("t5_addr", imem_addr, 10'h080);
    wait_out(20, ok);
    chk("t5_wait", ok, 1);
    chk("t5_pc", out_pc, 32'h200);
    tick();

    // PC wraps modulo 2^32
    redirect(32'hFFFF_FFF4);
    repeat (20) tick();

    // asynchronous reset mid-operation; stale responses must be ignored
    mem_lat = 3;
    repeat (10) tick();
    reset_b = 1'b1;
    exp_q.delete();
    exp_q.push_back(32'h0);
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_addr", imem_addr, 0);
    tick();
    reset_b = 1'b0;
    wait_out(30, ok);
    chk("mid_rst_wait", ok, 1);
    chk("mid_rst_pc", out_pc, 32'h0);
    tick();

    // 6: toggling grant, 3-cycle latency, 64 instructions
    gnt_mode = 1;
    mem_lat  = 3;
    start    = acc_cnt;
    ok       = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (acc_cnt - start >= 64) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t6_progress", ok, 1);

    // random grant, latency, backpressure and redirects
    gnt_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) mem_lat = $urandom_range(1, 4);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) redirect($urandom);
      else tick();
    end

    out_ready = 1'b1;
    gnt_mode  = 0;
    start     = acc_cnt;
    repeat (40) tick();
    chk("final_progress", (acc_cnt - start) >= 20, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
